// File: rtl/wb_trace_uart.sv
// Writeback trace monitor: captures register-file writes into a FIFO and
// streams each one as a 5-byte 8N1 UART record {dest, writeVal[31:24..7:0]}.
module wb_trace_uart #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          WB_EN,
    input  logic [4:0]                    dest,
    input  logic [31:0]                   writeVal,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count,
    output logic                          overflow
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_END = BW'(CPB - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [36:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic          ovf_q, ovf_d;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [39:0]   shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic          capture, pop, push, drop, baud_end;
    logic [7:0]    cur_byte;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    always_comb begin
        capture  = enable & WB_EN & (dest != 5'd0);
        pop      = (state_q == S_IDLE) & (count_q != '0);
        push     = capture & ((count_q != FULL) | pop);
        drop     = capture & ~push;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        ovf_d  = ovf_q | drop;
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        baud_end   = (baud_q == BAUD_END);
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d    = {3'b000, mem_q[rd_ptr_q]};
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd0;
                    baud_d     = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_idx_q < 3'd4) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        shift_d    = {shift_q[31:0], 8'h00};
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
        endcase

        // tx is computed from next state so the line moves on the same edge as the FSM.
        cur_byte = shift_d[39:32];
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) | (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dest, writeVal};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_wb_trace_uart.sv
// Bench for wb_trace_uart: queue-plus-frame-timer reference model, UART
// line decoder, and directed plus randomized scenarios.
module tb_wb_trace_uart;

    localparam int CLK_FREQ = 10;
    localparam int BAUD     = 1;
    localparam int DEPTH    = 8;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int TOT      = 50 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        WB_EN = 1'b0;
    logic [4:0]  dest = 5'd0;
    logic [31:0] writeVal = 32'd0;
    logic        tx, busy, overflow;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    wb_trace_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .WB_EN(WB_EN), .dest(dest),
        .writeVal(writeVal), .tx(tx), .busy(busy), .fifo_count(fifo_count),
        .drop_count(drop_count), .overflow(overflow)
    );

    // Reference model: pending records in a queue, one frame in flight timed
    // by a remaining-cycle count, and the frame as a 50-entry bit list.
    logic [36:0] m_q[$];
    logic [7:0]  m_bytes[$];
    bit          m_frame[50];
    int          m_rem = 0;
    int          m_drop = 0;
    bit          m_ovf = 1'b0;
    bit          m_tx = 1'b1;
    logic [36:0] m_rec;
    logic [39:0] m_r40;
    logic [7:0]  m_by;
    bit          m_pop, m_cap;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_rem  = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
            m_tx   = 1'b1;
        end else begin
            m_pop = (m_rem == 0) && (m_q.size() > 0);
            m_cap = enable && WB_EN && (dest != 5'd0);
            if (m_pop) begin
                m_rec = m_q.pop_front();
                m_r40 = {3'b000, m_rec};
                for (int b = 0; b < 5; b++) begin
                    m_by = 8'((m_r40 >> (32 - 8 * b)) & 40'hFF);
                    m_bytes.push_back(m_by);
                    m_frame[10 * b] = 1'b0;
                    for (int i = 0; i < 8; i++) m_frame[10 * b + 1 + i] = m_by[i];
                    m_frame[10 * b + 9] = 1'b1;
                end
                m_rem = TOT;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (m_cap) begin
                if (m_q.size() < DEPTH) m_q.push_back({dest, writeVal});
                else begin
                    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                    m_ovf  = 1'b1;
                end
            end
            m_tx = (m_rem > 0) ? m_frame[(TOT - m_rem) / CPB] : 1'b1;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors += 5;
            if (tx !== m_tx) begin
                miscompares++;
                $display("FAIL model_tx t=%0t got %b want %b", $time, tx, m_tx);
            end
            if (fifo_count !== 4'(m_q.size())) begin
                miscompares++;
                $display("FAIL model_count t=%0t got %0d want %0d", $time, fifo_count, m_q.size());
            end
            if (busy !== ((m_rem > 0) || (m_q.size() > 0))) begin
                miscompares++;
                $display("FAIL model_busy t=%0t got %b want %b", $time, busy, (m_rem > 0) || (m_q.size() > 0));
            end
            if (drop_count !== 8'(m_drop)) begin
                miscompares++;
                $display("FAIL model_drop t=%0t got %0d want %0d", $time, drop_count, m_drop);
            end
            if (overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL model_ovf t=%0t got %b want %b", $time, overflow, m_ovf);
            end
        end
    end

    // Host-side UART receiver sampling mid-bit.
    bit          rx_busy = 1'b0;
    int          rx_cnt = 0;
    int          rx_k;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_q[$];

    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_k = rx_cnt / CPB;
                if (rx_k >= 1 && rx_k <= 8) rx_sh[rx_k - 1] = tx;
                else if (rx_k == 9) begin
                    rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        WB_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        m_bytes.delete();
    endtask

    task automatic idle_wait(input int limit, output int n);
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (tx !== 1'b1)        begin miscompares++; $display("FAIL reset_tx got %b want 1", tx); end
        if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        if (drop_count !== 8'd0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        if (overflow !== 1'b0)  begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow); end
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] exp [5];
        int n;
        exp[0] = 8'h05; exp[1] = 8'h12; exp[2] = 8'h34; exp[3] = 8'h56; exp[4] = 8'h78;
        do_reset();
        enable = 1'b1; WB_EN = 1'b1; dest = 5'd5; writeVal = 32'h12345678;
        @(negedge clk);
        WB_EN = 1'b0;
        vectors += 2;
        if (fifo_count !== 4'd1) begin miscompares++; $display("FAIL single_peak got %0d want 1", fifo_count); end
        if (tx !== 1'b1)         begin miscompares++; $display("FAIL single_pre_tx got %b want 1", tx); end
        @(negedge clk);
        vectors += 3;
        if (tx !== 1'b0)         begin miscompares++; $display("FAIL single_start got %b want 0", tx); end
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL single_popped got %0d want 0", fifo_count); end
        if (busy !== 1'b1)       begin miscompares++; $display("FAIL single_busy got %b want 1", busy); end
        idle_wait(TOT + 50, n);
        vectors += 2;
        if (n !== TOT) begin miscompares++; $display("FAIL single_len got %0d want %0d", n, TOT); end
        if (rx_q.size() !== 5) begin miscompares++; $display("FAIL single_nbytes got %0d want 5", rx_q.size()); end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL single_byte%0d got %h want %h", i, rx_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_no_capture(input logic en, input logic [4:0] d, input logic [31:0] v);
        bit stayed_high = 1'b1;
        do_reset();
        enable = en; WB_EN = 1'b1; dest = d; writeVal = v;
        @(negedge clk);
        WB_EN = 1'b0; enable = 1'b1;
        vectors += 2;
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL nocap_count en=%b d=%0d got %0d want 0", en, d, fifo_count); end
        if (busy !== 1'b0)       begin miscompares++; $display("FAIL nocap_busy en=%b d=%0d got %b want 0", en, d, busy); end
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        vectors++;
        if (!stayed_high) begin miscompares++; $display("FAIL nocap_tx en=%b d=%0d got low want high", en, d); end
    endtask

    task automatic test_burst();
        int n;
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            WB_EN = 1'b1; dest = 5'(i); writeVal = $urandom;
            @(negedge clk);
        end
        WB_EN = 1'b0;
        vectors += 3;
        if (drop_count !== 8'd1) begin miscompares++; $display("FAIL burst_drop got %0d want 1", drop_count); end
        if (overflow !== 1'b1)   begin miscompares++; $display("FAIL burst_ovf got %b want 1", overflow); end
        if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL burst_count got %0d want 8", fifo_count); end
        idle_wait(10 * TOT, n);
        vectors += 2;
        if (n >= 10 * TOT) begin miscompares++; $display("FAIL burst_timeout got %0d want <%0d", n, 10 * TOT); end
        if (rx_q.size() !== 45) begin miscompares++; $display("FAIL burst_nbytes got %0d want 45", rx_q.size()); end
        for (int r = 0; r < 9 && 5 * r < rx_q.size(); r++) begin
            vectors++;
            if (rx_q[5 * r] !== 8'(r + 1)) begin
                miscompares++;
                $display("FAIL burst_dest%0d got %0d want %0d", r, rx_q[5 * r], r + 1);
            end
        end
        for (int i = 0; i < rx_q.size() && i < m_bytes.size(); i++) begin
            vectors++;
            if (rx_q[i] !== m_bytes[i]) begin
                miscompares++;
                $display("FAIL burst_data%0d got %h want %h", i, rx_q[i], m_bytes[i]);
            end
        end
    endtask

    task automatic test_full_pop();
        int n;
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            WB_EN = 1'b1; dest = 5'(i); writeVal = $urandom;
            @(negedge clk);
        end
        WB_EN = 1'b0;
        repeat (TOT - 7) @(negedge clk);
        vectors += 2;
        if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL fullpop_pre_count got %0d want 8", fifo_count); end
        if (tx !== 1'b1)         begin miscompares++; $display("FAIL fullpop_gap_tx got %b want 1", tx); end
        WB_EN = 1'b1; dest = 5'd20; writeVal = $urandom;
        @(negedge clk);
        WB_EN = 1'b0;
        vectors += 4;
        if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL fullpop_count got %0d want 8", fifo_count); end
        if (drop_count !== 8'd0) begin miscompares++; $display("FAIL fullpop_drop got %0d want 0", drop_count); end
        if (overflow !== 1'b0)   begin miscompares++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
        if (tx !== 1'b0)         begin miscompares++; $display("FAIL fullpop_start got %b want 0", tx); end
        idle_wait(10 * TOT, n);
        vectors += 2;
        if (rx_q.size() !== 50) begin miscompares++; $display("FAIL fullpop_nbytes got %0d want 50", rx_q.size()); end
        if (rx_q.size() == 50 && rx_q[45] !== 8'd20) begin
            miscompares++; $display("FAIL fullpop_last got %0d want 20", rx_q[45]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int n;
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            WB_EN = 1'b1; dest = 5'(i); writeVal = $urandom;
            @(negedge clk);
        end
        WB_EN = 1'b0;
        repeat (240) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors += 5;
        if (tx !== 1'b1)         begin miscompares++; $display("FAIL midrst_tx got %b want 1", tx); end
        if (busy !== 1'b0)       begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL midrst_count got %0d want 0", fifo_count); end
        if (overflow !== 1'b0)   begin miscompares++; $display("FAIL midrst_ovf got %b want 0", overflow); end
        if (drop_count !== 8'd0) begin miscompares++; $display("FAIL midrst_drop got %0d want 0", drop_count); end
        rst = 1'b0;
        rx_q.delete();
        m_bytes.delete();
        @(negedge clk);
        v = $urandom;
        WB_EN = 1'b1; dest = 5'd3; writeVal = v;
        @(negedge clk);
        WB_EN = 1'b0;
        idle_wait(2 * TOT, n);
        vectors++;
        if (rx_q.size() !== 5) begin miscompares++; $display("FAIL midrst_nbytes got %0d want 5", rx_q.size()); end
        if (rx_q.size() == 5) begin
            vectors++;
            if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4]} !== {8'd3, v}) begin
                miscompares++;
                $display("FAIL midrst_record got %h%h%h%h%h want %h%h", rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4], 8'd3, v);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        enable = 1'b1;
        repeat (300) begin
            WB_EN = 1'b1; dest = 5'($urandom_range(1, 31)); writeVal = $urandom;
            @(negedge clk);
        end
        WB_EN = 1'b0;
        vectors += 3;
        if (drop_count !== 8'd255) begin miscompares++; $display("FAIL sat_drop got %0d want 255", drop_count); end
        if (overflow !== 1'b1)     begin miscompares++; $display("FAIL sat_ovf got %b want 1", overflow); end
        if (fifo_count !== 4'd8)   begin miscompares++; $display("FAIL sat_count got %0d want 8", fifo_count); end
        do_reset();
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            enable   = ($urandom_range(0, 9) != 0);
            WB_EN    = ($urandom_range(0, 99) < 2);
            dest     = 5'($urandom_range(0, 31));
            writeVal = $urandom;
            @(negedge clk);
        end
        WB_EN = 1'b0; enable = 1'b1;
        idle_wait(12 * TOT, n);
        vectors += 2;
        if (n >= 12 * TOT) begin miscompares++; $display("FAIL rand_timeout got %0d want <%0d", n, 12 * TOT); end
        if (rx_q.size() !== m_bytes.size()) begin
            miscompares++; $display("FAIL rand_nbytes got %0d want %0d", rx_q.size(), m_bytes.size());
        end
        for (int i = 0; i < rx_q.size() && i < m_bytes.size(); i++) begin
            vectors++;
            if (rx_q[i] !== m_bytes[i]) begin
                miscompares++;
                $display("FAIL rand_data%0d got %h want %h", i, rx_q[i], m_bytes[i]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_no_capture(1'b1, 5'd0, 32'hFFFFFFFF);
        test_no_capture(1'b0, 5'd7, 32'hFFFFFFFF);
        test_burst();
        test_full_pop();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
